// File: rtl/ad_data_transmit.sv
// Purpose : ADC-side source of the dual-lane interleaved ADC bus (DBA even / DBB odd samples, DCO_P/DCO_N).
// Latency : a byte pair pushed into an empty FIFO in RUN reaches DBA within 3 adc_clk edges.
// Backpressure: s_ready drops when the byte FIFO is full or the block is powered down (OFF).
//
// Optional feature macro: ADC_TX_TEST_PATTERN_EN adds input test_pat_en and an 8-bit ramp source.
//
// Ports:
//   adc_clk, rst          bit clock (one DCO half-period per cycle), async active-high reset
//   s_data/s_valid/s_ready byte sample stream in A0,B0,A1,B1,... order
//   pdwn, DS              receiver power-down request and data-suppress control
//   DBA, DBB              lane A (launched on DCO_P rise), lane B (launched on DCO_P fall)
//   DCO_P, DCO_N          data clock at adc_clk/2 and its complement
//   running               high while in RUN
//   underflow             one-cycle pulse when a pair launch finds fewer than 2 bytes buffered
//   underflow_cnt         saturating count of underflow events
module ad_data_transmit #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned WAKE_CYCLES = 32,
    parameter logic [7:0]  IDLE_CODE   = 8'h80
) (
    input  logic        adc_clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        pdwn,
    input  logic        DS,
`ifdef ADC_TX_TEST_PATTERN_EN
    input  logic        test_pat_en,
`endif
    output logic [7:0]  DBA,
    output logic [7:0]  DBB,
    output logic        DCO_P,
    output logic        DCO_N,
    output logic        running,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]    state;
    logic          ph;
    logic [WW-1:0] wake_cnt;
    logic [7:0]    b_hold;

    // ------------------------------------------------------------------
    // Byte FIFO: one write per cycle, two-entry (pair) read per launch.
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [7:0]    rd_a;
    logic [7:0]    rd_b;
    logic          push;
    logic          pop;
    logic          flush;
    logic          launch_a;
    logic          launch_b;
    logic          pair_avail;

    assign s_ready    = (state != ST_OFF) && (fifo_count < CW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign flush      = (state == ST_OFF);
    assign pair_avail = (fifo_count >= CW'(2));

    // A launch happens on the edge where ph goes 0->1 (DCO_P rising),
    // B launch on the edge where ph goes 1->0 (DCO_P falling).
    // A pending power-down wins over any launch on the same edge.
    assign launch_a = (state == ST_RUN) && !ph && !pdwn;
    assign launch_b = (state == ST_RUN) &&  ph && !pdwn;

`ifdef ADC_TX_TEST_PATTERN_EN
    // The ramp source never touches the FIFO, so the buffered stream is kept intact.
    assign pop = launch_a && pair_avail && !test_pat_en;
`else
    assign pop = launch_a && pair_avail;
`endif

    assign rd_a = mem[rd_ptr];
    assign rd_b = mem[rd_ptr + AW'(1)];

    always_ff @(posedge adc_clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            // Powered-down: anything buffered (including a half pair) is dropped.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(2);
            end
            // pop is decided on the pre-push count, so a concurrent push and pop
            // nets out to +1 -2 without ever reading an entry written this cycle.
            fifo_count <= fifo_count + CW'(push) - (pop ? CW'(2) : CW'(0));
        end
    end

    // ------------------------------------------------------------------
    // Optional ramp generator
    // ------------------------------------------------------------------
`ifdef ADC_TX_TEST_PATTERN_EN
    logic [7:0] ramp;

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            ramp <= 8'h00;
        end else if (state != ST_RUN) begin
            // Restarts at zero every time RUN is entered.
            ramp <= 8'h00;
        end else if (launch_a && test_pat_en) begin
            ramp <= ramp + 8'd2;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Power/clock state machine and lane launch registers
    // ------------------------------------------------------------------
    // DCO_N is only the complement while the clock runs; in OFF both pins idle low.
    assign DCO_N   = (state != ST_OFF) && !DCO_P;
    assign running = (state == ST_RUN);

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_OFF;
            ph            <= 1'b0;
            wake_cnt      <= '0;
            DCO_P         <= 1'b0;
            DBA           <= 8'h00;
            DBB           <= 8'h00;
            b_hold        <= 8'h00;
            underflow     <= 1'b0;
            underflow_cnt <= 16'h0000;
        end else begin
            underflow <= 1'b0;
            if (pdwn) begin
                state  <= ST_OFF;
                ph     <= 1'b0;
                DCO_P  <= 1'b0;
                DBA    <= 8'h00;
                DBB    <= 8'h00;
                b_hold <= 8'h00;
            end else begin
                case (state)
                    ST_OFF: begin
                        state    <= ST_WAKE;
                        ph       <= 1'b0;
                        wake_cnt <= WW'(WAKE_CYCLES - 1);
                        DCO_P    <= 1'b0;
                        DBA      <= IDLE_CODE;
                        DBB      <= IDLE_CODE;
                        b_hold   <= IDLE_CODE;
                    end

                    ST_WAKE: begin
                        ph     <= ~ph;
                        DCO_P  <= ~ph;
                        DBA    <= IDLE_CODE;
                        DBB    <= IDLE_CODE;
                        b_hold <= IDLE_CODE;
                        if (wake_cnt != '0) begin
                            wake_cnt <= wake_cnt - WW'(1);
                        end else if (ph) begin
                            // Leaving on ph=1 makes the first RUN edge an A launch.
                            state <= ST_RUN;
                        end
                    end

                    ST_RUN: begin
                        ph    <= ~ph;
                        DCO_P <= ~ph;
                        if (launch_a) begin
`ifdef ADC_TX_TEST_PATTERN_EN
                            if (test_pat_en) begin
                                DBA    <= DS ? IDLE_CODE : ramp;
                                b_hold <= ramp + 8'd1;
                            end else
`endif
                            if (pair_avail) begin
                                // DS only masks the lanes; the pair is still consumed
                                // so the stream keeps its time-base.
                                DBA    <= DS ? IDLE_CODE : rd_a;
                                b_hold <= rd_b;
                            end else begin
                                DBA       <= IDLE_CODE;
                                b_hold    <= IDLE_CODE;
                                underflow <= 1'b1;
                                if (underflow_cnt != 16'hFFFF) begin
                                    underflow_cnt <= underflow_cnt + 16'd1;
                                end
                            end
                        end else if (launch_b) begin
                            DBB <= DS ? IDLE_CODE : b_hold;
                        end
                    end

                    default: begin
                        state  <= ST_OFF;
                        ph     <= 1'b0;
                        DCO_P  <= 1'b0;
                        DBA    <= 8'h00;
                        DBB    <= 8'h00;
                        b_hold <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule
